game_timer_ctrl: RTL and testbench
==================================

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50000000, ClockIn cycles per game second; legal range is 2 or more.
REQ-002 Parameter ROUND_SECONDS, default 60, round length in seconds; legal range 1..99; an out-of-range value SHALL fail elaboration.
REQ-003 Parameter BONUS_SECONDS, default 2, seconds added per hit; legal range 0..9.
REQ-004 ClockIn  input  1  clock; all state updates on the rising edge.
REQ-005 Reset  input  1  reset; Reset is synchronous, active-high; clock ClockIn.
REQ-006 Start  input  1  one-cycle pulse; starts or restarts a round.
REQ-007 Pause  input  1  level; while high, the countdown is frozen.
REQ-008 Hit  input  1  one-cycle pulse; a successful player hit.
REQ-009 OnesValue  output  4  BCD ones digit of seconds remaining, 0..9.
REQ-010 TensValue  output  4  BCD tens digit of seconds remaining, 0..9.
REQ-011 State  output  2  encoding: IDLE=0, RUNNING=1, PAUSED=2, DONE=3.
REQ-012 TimeUp  output  1  one-cycle pulse, asserted in the first cycle of DONE.
REQ-013 Running  output  1  high iff State==RUNNING.

Function
REQ-014 All outputs SHALL be registered and driven directly from flops; no combinational input-to-output path.
REQ-015 IDLE behaviour:
- Digits hold the BCD value of ROUND_SECONDS.
- On Start: go to RUNNING, reload the digits, and load the prescaler with CLOCK_FREQUENCY-1.
REQ-016 Prescaler:
- Decrements by one per cycle only in RUNNING with Pause low.
- On reaching 0, raises an internal tick for one cycle and reloads CLOCK_FREQUENCY-1.
- The first tick SHALL occur exactly CLOCK_FREQUENCY cycles after the RUNNING entry edge.
REQ-017 Tick in RUNNING decrements the two-digit BCD value:
- If OnesValue>0, ones decrements.
- If OnesValue==0, ones becomes 9 and tens decrements.
- Digits SHALL never hold a non-BCD code.
REQ-018 A tick that takes the value from 01 to 00 SHALL move State to DONE at the same edge; TimeUp is high for exactly that next cycle.
REQ-019 RUNNING with Pause high SHALL go to PAUSED; Pause has priority over a coincident tick, and both the decrement and the prescaler decrement are suppressed that cycle.
REQ-020 PAUSED behaviour:
- The prescaler value and digits are held, not reloaded.
- Pause low returns to RUNNING, and counting resumes from the held prescaler value.
REQ-021 DONE behaviour:
- Digits hold 00.
- Start reloads ROUND_SECONDS and the prescaler, then enters RUNNING.
REQ-022 Start in RUNNING or PAUSED SHALL be ignored.
REQ-023 Start and Pause both high in IDLE SHALL enter RUNNING; the next cycle enters PAUSED if Pause is still high.

Reset
REQ-024 Reset SHALL override all other inputs in any state, including mid-round and mid-pause.
REQ-025 Reset values:
- State=IDLE, Running=0, TimeUp=0.
- OnesValue=ROUND_SECONDS mod 10, TensValue=ROUND_SECONDS/10.
- Prescaler=CLOCK_FREQUENCY-1.

Configuration
REQ-026 Macro GAME_TIMER_BONUS_EN, when defined:
- A Hit in RUNNING with Pause low adds BONUS_SECONDS to the BCD value, saturating at 99.
- A Hit coincident with a tick applies the net change (+BONUS_SECONDS-1, saturating at 99).
- A value of 01 with a coincident tick and Hit, where BONUS_SECONDS>=1, yields BONUS_SECONDS and SHALL NOT enter DONE.
- Hit in any other state is ignored.
REQ-027 When GAME_TIMER_BONUS_EN is undefined, Hit SHALL be ignored in every state and the port SHALL remain present.

Verification (CLOCK_FREQUENCY=4, ROUND_SECONDS=12, BONUS_SECONDS=2)
REQ-028 Reset, then Start pulse -> Running=1; digits 1,2; first decrement to 11 exactly 4 cycles after entry; 02 reached after 40 cycles.
REQ-029 Full round -> value 01 to 00 at cycle 48 after entry, State=3, TimeUp high for exactly 1 cycle; a second Start reloads 12.
REQ-030 Pause raised 2 cycles after a tick for 10 cycles -> State=2, digits frozen; after release the next tick arrives 2 cycles later.
REQ-031 Borrow at value 10 -> next tick gives Tens=0, Ones=9; Reset asserted mid-pause -> State=0, digits 12, next cycle.
REQ-032 With GAME_TIMER_BONUS_EN, Hit at 98 -> 99 (saturated); Hit coincident with a tick at 01 -> 02 and State stays 1; without the macro, the same Hit leaves the value unchanged.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// Countdown round timer with BCD seconds display, pause support and a DONE pulse.
// Optional hit bonus is compiled in when GAME_TIMER_BONUS_EN is defined.
module game_timer_ctrl #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int ROUND_SECONDS   = 60,
    parameter int BONUS_SECONDS   = 2
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Hit,
    output logic [3:0] OnesValue,
    output logic [3:0] TensValue,
    output logic [1:0] State,
    output logic       TimeUp,
    output logic       Running
);

    localparam int PW = (CLOCK_FREQUENCY > 2) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLOCK_FREQUENCY - 1);
    localparam logic [3:0] ROUND_ONES = 4'(ROUND_SECONDS % 10);
    localparam logic [3:0] ROUND_TENS = 4'(ROUND_SECONDS / 10);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    generate
        if (ROUND_SECONDS < 1 || ROUND_SECONDS > 99) begin : g_bad_round
            $error("game_timer_ctrl: ROUND_SECONDS must be within 1..99");
        end
        if (CLOCK_FREQUENCY < 2) begin : g_bad_clock
            $error("game_timer_ctrl: CLOCK_FREQUENCY must be 2 or more");
        end
        if (BONUS_SECONDS < 0 || BONUS_SECONDS > 9) begin : g_bad_bonus
            $error("game_timer_ctrl: BONUS_SECONDS must be within 0..9");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          time_up_q, time_up_d;
    logic          running_q, running_d;

    logic       tick;
    logic [7:0] bonus_add;
    logic [7:0] secs_cur;
    logic [7:0] secs_sum;

`ifdef GAME_TIMER_BONUS_EN
    localparam logic [7:0] BONUS = 8'(BONUS_SECONDS);
`else
    logic unused_hit;
    assign unused_hit = Hit;
`endif

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        time_up_d = 1'b0;
        tick      = 1'b0;
        bonus_add = 8'd0;
        secs_cur  = 8'(tens_q) * 8'd10 + 8'(ones_q);
        secs_sum  = secs_cur;

        case (state_q)
            ST_IDLE: begin
                ones_d = ROUND_ONES;
                tens_d = ROUND_TENS;
                if (Start) begin
                    state_d = ST_RUNNING;
                    presc_d = PRESC_RELOAD;
                end
            end
            ST_RUNNING: begin
                // Pause wins over a coincident tick: nothing advances this cycle.
                if (Pause) begin
                    state_d = ST_PAUSED;
                end else begin
                    if (presc_q == '0) begin
                        tick    = 1'b1;
                        presc_d = PRESC_RELOAD;
                    end else begin
                        presc_d = presc_q - 1'b1;
                    end
`ifdef GAME_TIMER_BONUS_EN
                    if (Hit) begin
                        bonus_add = BONUS;
                    end
`endif
                    // Value is at least 1 while running, so this cannot underflow.
                    secs_sum = secs_cur + bonus_add - {7'd0, tick};
                    if (secs_sum > 8'd99) begin
                        secs_sum = 8'd99;
                    end
                    tens_d = 4'(secs_sum / 8'd10);
                    ones_d = 4'(secs_sum % 8'd10);
                    if (secs_sum == 8'd0) begin
                        state_d   = ST_DONE;
                        time_up_d = 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (!Pause) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_DONE: begin
                ones_d = 4'd0;
                tens_d = 4'd0;
                if (Start) begin
                    state_d = ST_RUNNING;
                    presc_d = PRESC_RELOAD;
                    ones_d  = ROUND_ONES;
                    tens_d  = ROUND_TENS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUNNING);
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= PRESC_RELOAD;
            ones_q    <= ROUND_ONES;
            tens_q    <= ROUND_TENS;
            time_up_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            time_up_q <= time_up_d;
            running_q <= running_d;
        end
    end

    assign OnesValue = ones_q;
    assign TensValue = tens_q;
    assign State     = state_q;
    assign TimeUp    = time_up_q;
    assign Running   = running_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl: directed scenarios then random stimulus,
// each cycle checked against a seconds/countdown reference model.
module tb_game_timer_ctrl;

    localparam int CF = 4;
    localparam int RS = 12;
    localparam int BS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Pause = 1'b0;
    logic       Hit   = 1'b0;
    logic [3:0] OnesValue;
    logic [3:0] TensValue;
    logic [1:0] State;
    logic       TimeUp;
    logic       Running;

    game_timer_ctrl #(
        .CLOCK_FREQUENCY(CF),
        .ROUND_SECONDS  (RS),
        .BONUS_SECONDS  (BS)
    ) dut (
        .ClockIn  (clk),
        .Reset    (Reset),
        .Start    (Start),
        .Pause    (Pause),
        .Hit      (Hit),
        .OnesValue(OnesValue),
        .TensValue(TensValue),
        .State    (State),
        .TimeUp   (TimeUp),
        .Running  (Running)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       tu;
        logic       run;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp, mon_act;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: whole seconds remaining and cycles left until the next tick.
    int m_st   = 0;   // 0 idle, 1 running, 2 paused, 3 done
    int m_secs = RS;
    int m_left = CF;
    bit m_tu   = 1'b0;
    bit bonus_on;

    initial begin
`ifdef GAME_TIMER_BONUS_EN
        bonus_on = 1'b1;
`else
        bonus_on = 1'b0;
`endif
    end

    function automatic void model_step(input bit r, input bit s, input bit p, input bit h);
        int delta;
        m_tu = 1'b0;
        if (r) begin
            m_st = 0; m_secs = RS; m_left = CF;
        end else begin
            case (m_st)
                0: if (s) begin m_st = 1; m_secs = RS; m_left = CF; end
                1: begin
                    if (p) begin
                        m_st = 2;
                    end else begin
                        delta = 0;
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            delta = -1;
                            m_left = CF;
                        end
                        if (bonus_on && h) delta = delta + BS;
                        m_secs = m_secs + delta;
                        if (m_secs > 99) m_secs = 99;
                        if (m_secs == 0) begin
                            m_st = 3;
                            m_tu = 1'b1;
                        end
                    end
                end
                2: if (!p) m_st = 1;
                default: if (s) begin m_st = 1; m_secs = RS; m_left = CF; end
            endcase
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st   = 2'(m_st);
        o.tens = 4'(m_secs / 10);
        o.ones = 4'(m_secs % 10);
        o.tu   = m_tu;
        o.run  = (m_st == 1);
        return o;
    endfunction

    task automatic drive(input bit r, input bit s, input bit p, input bit h);
        @(negedge clk);
        Reset = r; Start = s; Pause = p; Hit = h;
        model_step(r, s, p, h);
        exp_q.push_back(model_obs());
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {State, TensValue, OnesValue, TimeUp, Running};
                n_checks++;
                if (mon_act === mon_exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_check t=%0t got st=%0d val=%0d%0d tu=%0b run=%0b want st=%0d val=%0d%0d tu=%0b run=%0b",
                             $time, mon_act.st, mon_act.tens, mon_act.ones, mon_act.tu, mon_act.run,
                             mon_exp.st, mon_exp.tens, mon_exp.ones, mon_exp.tu, mon_exp.run);
                end
            end
        end
    end

    initial begin
        int  guard;
        bit  pl;
        bit  busy_hits;

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        // Full round: start, count down to DONE, linger, restart.
        drive(0, 1, 0, 0);
        repeat (52) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        // Pause two cycles after the first tick for ten cycles.
        repeat (6) drive(0, 0, 0, 0);
        repeat (10) drive(0, 0, 1, 0);
        repeat (14) drive(0, 0, 0, 0);
        // Start ignored while running and paused, then reset mid-pause.
        drive(0, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0);
        drive(0, 1, 1, 0);
        drive(1, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0);
        // Start with Pause held in IDLE.
        drive(0, 1, 1, 0);
        repeat (2) drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        // Hit storm toward saturation.
        repeat (60) drive(0, 0, 0, 1);
        // Bring value to 01 and land a Hit on the tick edge.
        guard = 0;
        while (m_st == 1 && m_secs != 1 && guard < 600) begin
            drive(0, 0, 0, 0);
            guard++;
        end
        while (m_st == 1 && m_left != 1 && guard < 600) begin
            drive(0, 0, 0, 0);
            guard++;
        end
        drive(0, 0, 0, 1);
        repeat (10) drive(0, 0, 0, 0);

        pl = 1'b0;
        busy_hits = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) busy_hits = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 14) == 0) pl = ~pl;
            drive($urandom_range(0, 399) == 0,
                  $urandom_range(0, 59) == 0,
                  pl,
                  busy_hits ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0));
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain got %0d pending entries want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
